// File: rtl/ber_counter.sv
// Bit-error-rate window counter: accumulates flipped bits and errored words
// over WORDS valid noise words, then holds the result until acknowledged.
//
// state | meaning
// IDLE  | waiting for start, last result held on outputs
// ACCUM | accumulating valid mask words into the window
// DONE  | window complete, result held until ack
module ber_counter #(
    parameter int WORDS = 1024,
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             ack,
    input  logic [15:0]      mask,
    input  logic             mask_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] bit_errors,
    output logic [15:0]      word_errors
);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    localparam logic [15:0] LAST = 16'(WORDS - 1);

    state_t           state;
    logic [CNT_W-1:0] bit_acc;
    logic [15:0]      werr_acc;
    logic [15:0]      words_left;

    logic [4:0]       pc;
    logic [CNT_W:0]   bit_sum;
    logic [CNT_W-1:0] bit_next;
    logic [15:0]      werr_next;

    // Saturating next-values of both accumulators for the word on mask this cycle.
    always_comb begin
        pc = '0;
        for (int i = 0; i < 16; i++) begin
            pc = pc + 5'(mask[i]);
        end
        bit_sum   = {1'b0, bit_acc} + (CNT_W+1)'(pc);
        bit_next  = bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];
        werr_next = ((mask != 16'h0) && (werr_acc != 16'hFFFF)) ? werr_acc + 16'd1 : werr_acc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            bit_acc     <= '0;
            werr_acc    <= '0;
            words_left  <= '0;
            bit_errors  <= '0;
            word_errors <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= ACCUM;
                        busy       <= 1'b1;
                        bit_acc    <= '0;
                        werr_acc   <= '0;
                        words_left <= LAST;
                    end
                end
                ACCUM: begin
                    if (mask_valid) begin
                        bit_acc  <= bit_next;
                        werr_acc <= werr_next;
                        // words_left is a down-counter; zero means this is the final word
                        if (words_left == 16'd0) begin
                            bit_errors  <= bit_next;
                            word_errors <= werr_next;
                            state       <= DONE;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                        end else begin
                            words_left <= words_left - 16'd1;
                        end
                    end
                end
                DONE: begin
                    if (ack) begin
                        done <= 1'b0;
                        if (start) begin
                            state      <= ACCUM;
                            busy       <= 1'b1;
                            bit_acc    <= '0;
                            werr_acc   <= '0;
                            words_left <= LAST;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
